// File: rtl/vga_timing_pkg.sv
// Shared VGA timing parameter sets, sync polarity constants and the
// porch/sync total helper used by the parameterised timing generator.
package vga_timing_pkg;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          hs_pol;
    bit          vs_pol;
  } vga_timing_t;

  localparam vga_timing_t XGA_65M = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
    hs_pol: POL_LOW, vs_pol: POL_LOW
  };

  localparam vga_timing_t SVGA_40M = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: POL_HIGH, vs_pol: POL_HIGH
  };

  localparam vga_timing_t VGA_25M = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: POL_LOW, vs_pol: POL_LOW
  };

  function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Reset-clearing shift register that re-times the whole timing bundle so it
// stays aligned with deeper pixel pipelines. DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q_o = d_i;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] pipe_q;

      // Shifts every clock regardless of pixel enable: fixed clk latency.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= d_i;
          for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign q_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen_p.sv
// Parameterised VGA timing generator: h/v counters, registered sync/blank/DE
// decode, line/frame strobes, frame counter and an optional output delay line.
module vga_timing_gen_p
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = XGA_65M.h_active,
  parameter int unsigned H_FP     = XGA_65M.h_fp,
  parameter int unsigned H_SYNC   = XGA_65M.h_sync,
  parameter int unsigned H_BP     = XGA_65M.h_bp,
  parameter int unsigned V_ACTIVE = XGA_65M.v_active,
  parameter int unsigned V_FP     = XGA_65M.v_fp,
  parameter int unsigned V_SYNC   = XGA_65M.v_sync,
  parameter int unsigned V_BP     = XGA_65M.v_bp,
  parameter bit          HS_POL   = XGA_65M.hs_pol,
  parameter bit          VS_POL   = XGA_65M.vs_pol,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PIPE_DLY = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             hblnk_o,
  output logic             vblnk_o,
  output logic             de_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic [15:0]      frame_cnt_o
);

  localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam longint unsigned CNT_RANGE = 64'(1) << CNT_W;

  generate
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_term
      $error("vga_timing_gen_p: every porch/sync/active term must be non-zero");
    end
    if (PIPE_DLY > 7) begin : g_bad_dly
      $error("vga_timing_gen_p: PIPE_DLY must be 0..7");
    end
    if (CNT_W == 0 || CNT_W > 32 ||
        64'(H_TOTAL) > CNT_RANGE || 64'(V_TOTAL) > CNT_RANGE) begin : g_bad_w
      $error("vga_timing_gen_p: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned PW = 2 * CNT_W + 23;

  // Internal counters park on the last position so the first ce lands on (0,0).
  logic [CNT_W-1:0] h_q, v_q, h_d, v_d;
  logic             h_wrap;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + CNT_W'(1);
    v_d    = v_q;
    if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= H_LAST;
      v_q <= V_LAST;
    end else if (ce_i) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Decode from next-state values so counts and decode move together.
  logic hs_act_d, vs_act_d, hblnk_d, vblnk_d, ls_d, fs_d;

  always_comb begin
    hs_act_d = (h_d >= HS_BEG) && (h_d < HS_END);
    vs_act_d = (v_d >= VS_BEG) && (v_d < VS_END);
    hblnk_d  = (h_d >= H_ACT);
    vblnk_d  = (v_d >= V_ACT);
    ls_d     = (h_d == '0);
    fs_d     = ls_d && (v_d == '0);
  end

  logic [CNT_W-1:0] hcount_q, vcount_q;
  logic             hs_act_q, vs_act_q, hblnk_q, vblnk_q, de_q, ls_q, fs_q;
  logic [15:0]      fcnt_q;

  // Sync is carried active-high so a cleared stage always reads as inactive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hs_act_q <= 1'b0;
      vs_act_q <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      de_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      fcnt_q   <= '0;
    end else if (ce_i) begin
      hcount_q <= h_d;
      vcount_q <= v_d;
      hs_act_q <= hs_act_d;
      vs_act_q <= vs_act_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      de_q     <= ~hblnk_d & ~vblnk_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      if (fs_d) fcnt_q <= fcnt_q + 16'd1;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end
  end

  logic [PW-1:0] bundle_d, bundle_q;
  logic          hs_act_o, vs_act_o;

  assign bundle_d = {hcount_q, vcount_q, hs_act_q, vs_act_q, hblnk_q, vblnk_q,
                     de_q, ls_q, fs_q, fcnt_q};

  vga_delay_line #(
    .W     (PW),
    .DEPTH (PIPE_DLY)
  ) u_dly (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bundle_d),
    .q_o    (bundle_q)
  );

  assign {hcount_o, vcount_o, hs_act_o, vs_act_o, hblnk_o, vblnk_o,
          de_o, line_start_o, frame_start_o, frame_cnt_o} = bundle_q;

  assign hsync_o = HS_POL ? hs_act_o : ~hs_act_o;
  assign vsync_o = VS_POL ? vs_act_o : ~vs_act_o;

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Directed bench for vga_timing_gen_p: small 14x8 raster (PIPE_DLY 0 and 3)
// plus a default XGA instance, all sharing clock, reset and pixel enable.
module tb_vga_timing_gen_p;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] hc0, vc0, hc3, vc3;
  logic hs0, vs0, hb0, vb0, de0, ls0, fs0;
  logic hs3, vs3, hb3, vb3, de3, ls3, fs3;
  logic [15:0] fc0, fc3;
  logic [15:0] hcx, vcx, fcx;
  logic hsx, vsx, hbx, vbx, dex, lsx, fsx;

  vga_timing_gen_p #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
    .CNT_W(CW), .PIPE_DLY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .hcount_o(hc0), .vcount_o(vc0),
    .hsync_o(hs0), .vsync_o(vs0), .hblnk_o(hb0), .vblnk_o(vb0), .de_o(de0),
    .line_start_o(ls0), .frame_start_o(fs0), .frame_cnt_o(fc0));

  vga_timing_gen_p #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
    .CNT_W(CW), .PIPE_DLY(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .hcount_o(hc3), .vcount_o(vc3),
    .hsync_o(hs3), .vsync_o(vs3), .hblnk_o(hb3), .vblnk_o(vb3), .de_o(de3),
    .line_start_o(ls3), .frame_start_o(fs3), .frame_cnt_o(fc3));

  vga_timing_gen_p dutx (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .hcount_o(hcx), .vcount_o(vcx),
    .hsync_o(hsx), .vsync_o(vsx), .hblnk_o(hbx), .vblnk_o(vbx), .de_o(dex),
    .line_start_o(lsx), .frame_start_o(fsx), .frame_cnt_o(fcx));

  logic [2*CW+22:0] b0, b3;
  assign b0 = {hc0, vc0, hs0, vs0, hb0, vb0, de0, ls0, fs0, fc0};
  assign b3 = {hc3, vc3, hs3, vs3, hb3, vb3, de3, ls3, fs3, fc3};

  int pass_cnt = 0;
  int tot_cnt = 0;
  int mh = 0;
  int mv = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    mh = (mh == 13) ? 0 : mh + 1;
    if (mh == 0) mv = (mv == 7) ? 0 : mv + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1;
    repeat (3) tick();
    tot_cnt++; if ({hc0, vc0} !== '0) $display("FAIL reset_count: got h=%0d v=%0d want 0/0", hc0, vc0); else pass_cnt++;
    tot_cnt++; if ({hs0, vs0, hb0, vb0, de0, ls0, fs0} !== 7'b0) $display("FAIL reset_flags: got %b want 0000000", {hs0, vs0, hb0, vb0, de0, ls0, fs0}); else pass_cnt++;
    tot_cnt++; if (fc0 !== 16'd0) $display("FAIL reset_fcnt: got %0d want 0", fc0); else pass_cnt++;
    tot_cnt++; if (b3 !== '0) $display("FAIL reset_dly3: got %h want 0", b3); else pass_cnt++;
    tot_cnt++; if ({hsx, vsx, dex, fcx} !== {1'b1, 1'b1, 1'b0, 16'd0}) $display("FAIL reset_xga: got hs=%b vs=%b de=%b fc=%0d want 1 1 0 0", hsx, vsx, dex, fcx); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    mh = 0; mv = 0;
    tot_cnt++; if ({hc0, vc0} !== '0) $display("FAIL first_pos: got h=%0d v=%0d want 0/0", hc0, vc0); else pass_cnt++;
    tot_cnt++; if ({de0, ls0, fs0} !== 3'b111) $display("FAIL first_strobes: got de/ls/fs=%b want 111", {de0, ls0, fs0}); else pass_cnt++;
    tot_cnt++; if (fc0 !== 16'd1) $display("FAIL first_fcnt: got %0d want 1", fc0); else pass_cnt++;
  endtask

  task automatic test_line();
    for (int k = 1; k <= 13; k++) begin
      tick();
      adv();
      tot_cnt++; if (int'(hc0) !== k || vc0 !== 8'd0) $display("FAIL line_count: got h=%0d v=%0d want %0d/0", hc0, vc0, k); else pass_cnt++;
      tot_cnt++; if (hb0 !== (k >= 8) || de0 !== (k < 8)) $display("FAIL line_hblnk h=%0d: got hb=%b de=%b", k, hb0, de0); else pass_cnt++;
      tot_cnt++; if (hs0 !== (k >= 10 && k <= 12)) $display("FAIL line_hsync h=%0d: got %b", k, hs0); else pass_cnt++;
      tot_cnt++; if (ls0 !== 1'b0 || fs0 !== 1'b0) $display("FAIL line_strobe h=%0d: got ls=%b fs=%b want 0 0", k, ls0, fs0); else pass_cnt++;
    end
    tick();
    adv();
    tot_cnt++; if (hc0 !== 8'd0 || vc0 !== 8'd1) $display("FAIL line_wrap: got h=%0d v=%0d want 0/1", hc0, vc0); else pass_cnt++;
    tot_cnt++; if (ls0 !== 1'b1 || fs0 !== 1'b0) $display("FAIL line_wrap_strobe: got ls=%b fs=%b want 1 0", ls0, fs0); else pass_cnt++;
  endtask

  task automatic test_frame();
    for (int n = 1; n <= 98; n++) begin
      tick();
      adv();
      tot_cnt++; if (int'(hc0) !== mh || int'(vc0) !== mv) $display("FAIL frame_count: got h=%0d v=%0d want %0d/%0d", hc0, vc0, mh, mv); else pass_cnt++;
      tot_cnt++; if (vs0 !== (mv >= 5 && mv <= 6) || vb0 !== (mv >= 4)) $display("FAIL frame_vdecode v=%0d: got vs=%b vb=%b", mv, vs0, vb0); else pass_cnt++;
      tot_cnt++; if (de0 !== (mh < 8 && mv < 4)) $display("FAIL frame_de h=%0d v=%0d: got %b", mh, mv, de0); else pass_cnt++;
      tot_cnt++; if (fs0 !== (n == 98)) $display("FAIL frame_fs n=%0d: got %b", n, fs0); else pass_cnt++;
    end
    tot_cnt++; if (fc0 !== 16'd2) $display("FAIL frame_fcnt: got %0d want 2", fc0); else pass_cnt++;
  endtask

  task automatic test_ce_alt();
    int ls_n = 0;
    int fs_n = 0;
    for (int i = 0; i < 224; i++) begin
      ce = (i % 2 == 1);
      tick();
      if (ce) adv();
      if (ls0) ls_n++;
      if (fs0) fs_n++;
      tot_cnt++; if (int'(hc0) !== mh || int'(vc0) !== mv) $display("FAIL ce_hold i=%0d: got h=%0d v=%0d want %0d/%0d", i, hc0, vc0, mh, mv); else pass_cnt++;
      tot_cnt++; if (ls0 !== (ce && mh == 0)) $display("FAIL ce_ls i=%0d: got %b", i, ls0); else pass_cnt++;
    end
    tot_cnt++; if (ls_n !== 8) $display("FAIL ce_ls_count: got %0d want 8", ls_n); else pass_cnt++;
    tot_cnt++; if (fs_n !== 1 || fs0 !== 1'b1) $display("FAIL ce_frame_224: got fs_n=%0d fs=%b want 1 1", fs_n, fs0); else pass_cnt++;
    tot_cnt++; if (fc0 !== 16'd3) $display("FAIL ce_fcnt: got %0d want 3", fc0); else pass_cnt++;
  endtask

  task automatic test_pipe_delay();
    logic [2*CW+22:0] hist [64];
    for (int i = 0; i < 64; i++) begin
      ce = (i % 3 != 0);
      tick();
      hist[i] = b0;
      if (i >= 3) begin
        tot_cnt++; if (b3 !== hist[i-3]) $display("FAIL pipe_dly3 i=%0d: got %h want %h", i, b3, hist[i-3]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    ce = 1'b1;
    while (!(hc0 == 8'd5 && vc0 == 8'd2) && k < 300) begin
      tick();
      k++;
    end
    tot_cnt++; if (k >= 300) $display("FAIL mid_reach: got timeout want h=5 v=2"); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    tot_cnt++; if ({hc0, vc0, fc0} !== '0) $display("FAIL mid_async: got h=%0d v=%0d fc=%0d want 0", hc0, vc0, fc0); else pass_cnt++;
    tot_cnt++; if ({hs0, vs0, hb0, vb0, de0} !== 5'b0) $display("FAIL mid_flags: got %b want 00000", {hs0, vs0, hb0, vb0, de0}); else pass_cnt++;
    tot_cnt++; if (b3 !== '0) $display("FAIL mid_dly3: got %h want 0", b3); else pass_cnt++;
    tot_cnt++; if (hsx !== 1'b1 || vsx !== 1'b1) $display("FAIL mid_xga_sync: got %b%b want 11", hsx, vsx); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    tot_cnt++; if ({hc0, vc0} !== '0 || fs0 !== 1'b1 || ls0 !== 1'b1) $display("FAIL mid_restart: got h=%0d v=%0d fs=%b ls=%b want 0 0 1 1", hc0, vc0, fs0, ls0); else pass_cnt++;
    tot_cnt++; if (fc0 !== 16'd1) $display("FAIL mid_fcnt: got %0d want 1", fc0); else pass_cnt++;
  endtask

  task automatic test_xga();
    int n = 0;
    int lo = 0;
    int first_lo = -1;
    int first_hb = -1;
    ce = 1'b1;
    tot_cnt++; if (lsx !== 1'b1 || hcx !== 16'd0) $display("FAIL xga_start: got ls=%b h=%0d want 1 0", lsx, hcx); else pass_cnt++;
    do begin
      tick();
      n++;
      if (!hsx) begin
        lo++;
        if (first_lo < 0) first_lo = int'(hcx);
      end
      if (hbx && first_hb < 0) first_hb = int'(hcx);
    end while (!lsx && n < 2000);
    tot_cnt++; if (n !== 1344) $display("FAIL xga_line_len: got %0d want 1344", n); else pass_cnt++;
    tot_cnt++; if (lo !== 136) $display("FAIL xga_hsync_len: got %0d want 136", lo); else pass_cnt++;
    tot_cnt++; if (first_lo !== 1048) $display("FAIL xga_hsync_start: got %0d want 1048", first_lo); else pass_cnt++;
    tot_cnt++; if (first_hb !== 1024) $display("FAIL xga_hblnk_start: got %0d want 1024", first_hb); else pass_cnt++;
    tot_cnt++; if (vcx !== 16'd1 || hcx !== 16'd0) $display("FAIL xga_wrap: got h=%0d v=%0d want 0/1", hcx, vcx); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_ce_alt();
    test_pipe_delay();
    test_reset_mid();
    test_xga();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
